bcd_counter_n: RTL and testbench

- Parametrised N-digit BCD up/down counter feeding the TM1638 display digit path. Successor to the fixed 3-digit, switch-driven BCD block.
- Adds a selectable decade step, wrap or saturate mode, and a terminal-event pulse.
- Adds a binary preload path: an iterative double-dabble converter behind a valid/ready handshake.
- Output is a packed BCD word; digit 0 (least significant) is in bits [3:0].

---
 rtl/bcd_counter_n.sv | 274 +++++++++++++++++++++++++++
 tb/tb_bcd_counter_n.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_n.sv
// ---------------------------------------------------------------------------
// bcd_counter_n
//
// N-digit packed-BCD up/down counter for the TM1638 display digit path.
// Each enabled cycle the count moves by 10^step_idx, either wrapping modulo
// 10^DIGITS or saturating at 0 / all nines, and "wrap" pulses whenever a
// step crosses a range limit. A binary value can be preloaded through an
// iterative double-dabble converter (BIN_W shift cycles plus one commit
// cycle) behind a valid/ready handshake.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   en          count enable, one step per cycle
//   up          1 = increment, 0 = decrement
//   step_idx    step size is 10^step_idx (no-op when >= DIGITS)
//   sat_mode    1 = saturate at the limits, 0 = wrap
//   load_valid  binary preload request
//   load_ready  converter idle, preload can be accepted
//   bin_in      binary preload value
//   bcd_out     current count, digit 0 in bits [3:0]
//   wrap        one-cycle pulse, step crossed a range limit
//   done        one-cycle pulse, preload committed
//   load_err    one-cycle pulse with done, preload value out of range
//   blank       (only with BCD_COUNTER_BLANK_EN) leading-zero blanking mask
//
// Optional feature macro: BCD_COUNTER_BLANK_EN
// ---------------------------------------------------------------------------
module bcd_counter_n #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14,
    parameter int STEP_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic [STEP_W-1:0]     step_idx,
    input  logic                  sat_mode,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  wrap,
    output logic                  done,
`ifdef BCD_COUNTER_BLANK_EN
    output logic [DIGITS-1:0]     blank,
`endif
    output logic                  load_err
);

    // Number of decimal digits needed to hold 2^w - 1.
    function automatic int dec_digits(input int w);
        longint unsigned v;
        int n;
        v = (64'd1 << w) - 64'd1;
        n = 1;
        v = v / 10;
        while (v != 0) begin
            n = n + 1;
            v = v / 10;
        end
        return n;
    endfunction

    localparam int SCR_N = dec_digits(BIN_W);
    localparam int SW    = 4 * SCR_N;
    localparam int BW    = 4 * DIGITS;
    localparam int EXT_N = (SCR_N > DIGITS) ? SCR_N : DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;

    logic [BIN_W-1:0]   bin_sr;
    logic [SW-1:0]      scratch;
    logic [SW-1:0]      scr_adj;
    logic [4*EXT_N-1:0] scr_ext;
    logic [CNT_W-1:0]   bit_cnt;
    logic               over_range;
    logic [BW-1:0]      commit_val;

    logic [BW-1:0]      step_res;
    logic               step_ok;
    logic               step_cross;
    logic [4:0]         dig_t;
    logic               inc_b;
    logic               carry_b;

    logic [BW-1:0]      bcd_nxt;
    logic               wrap_nxt;
    logic               done_nxt;
    logic               err_nxt;

    assign accept = load_valid && load_ready;

    // State register of the preload FSM; reset aborts any conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> CONV on an accepted preload, BIN_W shift
    // cycles in CONV, then a single COMMIT cycle back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_valid) state_nxt = CONV;
            CONV:    if (bit_cnt == CNT_W'(BIN_W - 1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        load_ready = (state == IDLE);
    end

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        scr_adj = scratch;
        for (int i = 0; i < SCR_N; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Commit value: the scratch register is widened to at least DIGITS
    // nibbles so that both narrow and wide converters index safely; any
    // nonzero nibble above the display range forces all nines.
    always_comb begin
        scr_ext          = '0;
        scr_ext[SW-1:0]  = scratch;
        over_range       = 1'b0;
        for (int i = DIGITS; i < EXT_N; i++) begin
            if (scr_ext[4*i +: 4] != 4'd0) begin
                over_range = 1'b1;
            end
        end
        commit_val = over_range ? ALL_NINES : scr_ext[BW-1:0];
    end

    // Decimal step: add or subtract a single 1 at digit step_idx and ripple
    // the carry/borrow through all digits. A carry or borrow out of the top
    // digit is exactly a range crossing; the rippled result is already the
    // wrapped value, saturation replaces it with the limit.
    always_comb begin
        step_res = bcd_out;
        step_ok  = (int'(step_idx) < DIGITS);
        carry_b  = 1'b0;
        dig_t    = 5'd0;
        inc_b    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            inc_b = (i == int'(step_idx));
            if (up) begin
                dig_t = {1'b0, bcd_out[4*i +: 4]} + {4'd0, inc_b} + {4'd0, carry_b};
                if (dig_t > 5'd9) begin
                    dig_t   = dig_t - 5'd10;
                    carry_b = 1'b1;
                end else begin
                    carry_b = 1'b0;
                end
            end else begin
                dig_t = {1'b0, bcd_out[4*i +: 4]} - {4'd0, inc_b} - {4'd0, carry_b};
                if (dig_t[4]) begin
                    dig_t   = dig_t + 5'd10;
                    carry_b = 1'b1;
                end else begin
                    carry_b = 1'b0;
                end
            end
            step_res[4*i +: 4] = dig_t[3:0];
        end
        step_cross = carry_b;
        if (carry_b && sat_mode) begin
            step_res = up ? ALL_NINES : '0;
        end
    end

    // Next display value and event pulses. Counting only happens in IDLE
    // when no preload is being accepted on the same edge.
    always_comb begin
        bcd_nxt  = bcd_out;
        wrap_nxt = 1'b0;
        done_nxt = 1'b0;
        err_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!accept && en && step_ok) begin
                    bcd_nxt  = step_res;
                    wrap_nxt = step_cross;
                end
            end
            COMMIT: begin
                bcd_nxt  = commit_val;
                done_nxt = 1'b1;
                err_nxt  = over_range;
            end
            default: ;
        endcase
    end

    // Count register, event pulses and converter datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_out  <= '0;
            wrap     <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
            bin_sr   <= '0;
            scratch  <= '0;
            bit_cnt  <= '0;
        end else begin
            bcd_out  <= bcd_nxt;
            wrap     <= wrap_nxt;
            done     <= done_nxt;
            load_err <= err_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bin_sr  <= bin_in;
                        scratch <= '0;
                        bit_cnt <= '0;
                    end
                end
                CONV: begin
                    scratch <= SW'({scr_adj, bin_sr[BIN_W-1]});
                    bin_sr  <= bin_sr << 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_COUNTER_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              zero_above;

    // Leading-zero mask computed from the value about to be registered, so
    // it changes on the same edge as bcd_out. Digit 0 is never blanked.
    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above && (bcd_nxt[4*i +: 4] == 4'd0);
            blank_nxt[i] = zero_above;
        end
    end

    // Blank register; reset value matches a count of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            blank <= ~DIGITS'(1);
        end else begin
            blank <= blank_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_counter_n.sv
// ---------------------------------------------------------------------------
// tb_bcd_counter_n
//
// Self-checking bench for bcd_counter_n (DIGITS=3, BIN_W=10, STEP_W=2).
// A value-level model (plain integer arithmetic plus a preload countdown)
// predicts every output each cycle; directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_bcd_counter_n;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int STEP_W = 2;
    localparam int MAXV   = 999;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                up;
    logic [STEP_W-1:0]   step_idx;
    logic                sat_mode;
    logic                load_valid;
    logic                load_ready;
    logic [BIN_W-1:0]    bin_in;
    logic [4*DIGITS-1:0] bcd_out;
    logic                wrap;
    logic                done;
    logic                load_err;
`ifdef BCD_COUNTER_BLANK_EN
    logic [DIGITS-1:0]   blank;
`endif

    bcd_counter_n #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W),
        .STEP_W (STEP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .up         (up),
        .step_idx   (step_idx),
        .sat_mode   (sat_mode),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .bin_in     (bin_in),
        .bcd_out    (bcd_out),
        .wrap       (wrap),
        .done       (done),
`ifdef BCD_COUNTER_BLANK_EN
        .blank      (blank),
`endif
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 1'b0;

    // Reference model state: count value, cycles left in a preload, and
    // the pulses expected after the most recent edge.
    int m_val  = 0;
    int m_busy = 0;
    int m_bin  = 0;
    bit m_wrap = 1'b0;
    bit m_done = 1'b0;
    bit m_err  = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        end
        return r;
    endfunction

    // Model update at each rising edge, from the inputs being sampled.
    always @(posedge clk) begin
        int nv;
        int st;
        m_wrap = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            m_val  = 0;
            m_busy = 0;
        end else if (m_busy > 0) begin
            m_busy = m_busy - 1;
            if (m_busy == 0) begin
                m_done = 1'b1;
                if (m_bin > MAXV) begin
                    m_val = MAXV;
                    m_err = 1'b1;
                end else begin
                    m_val = m_bin;
                end
            end
        end else if (load_valid) begin
            m_bin  = int'(bin_in);
            m_busy = BIN_W + 1;
        end else if (en && int'(step_idx) < DIGITS) begin
            st = 10 ** int'(step_idx);
            if (up) begin
                nv = m_val + st;
                if (nv > MAXV) begin
                    m_wrap = 1'b1;
                    nv = sat_mode ? MAXV : nv - (MAXV + 1);
                end
            end else begin
                nv = m_val - st;
                if (nv < 0) begin
                    m_wrap = 1'b1;
                    nv = sat_mode ? 0 : nv + (MAXV + 1);
                end
            end
            m_val = nv;
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            checkOutput("model_bcd_out", 32'(bcd_out), 32'(to_bcd(m_val)));
            checkOutput("model_wrap", 32'(wrap), 32'(m_wrap));
            checkOutput("model_done", 32'(done), 32'(m_done));
            checkOutput("model_load_err", 32'(load_err), 32'(m_err));
            checkOutput("model_load_ready", 32'(load_ready), 32'(m_busy == 0));
`ifdef BCD_COUNTER_BLANK_EN
            begin
                logic [DIGITS-1:0] eb;
                eb = '0;
                for (int i = 1; i < DIGITS; i++) begin
                    eb[i] = ((m_val / (10 ** i)) == 0);
                end
                checkOutput("model_blank", 32'(blank), 32'(eb));
            end
`endif
        end
    end

    // Drive one cycle of inputs; returns just after the following falling edge.
    task automatic applyStimulus(input bit r, input bit e, input bit u,
                                 input int s, input bit sat, input bit lv,
                                 input int b);
        rst        = r;
        en         = e;
        up         = u;
        step_idx   = STEP_W'(s);
        sat_mode   = sat;
        load_valid = lv;
        bin_in     = BIN_W'(b);
        @(negedge clk);
        #1;
    endtask

    // Preload a value, checking that the counter stays frozen and
    // load_ready stays low until the commit edge.
    task automatic doLoad(input int value, input bit keep_en,
                          input logic [11:0] held);
        applyStimulus(0, keep_en, 1, 0, 0, 1, value);
        for (int k = 0; k < BIN_W + 1; k++) begin
            checkOutput("load_ready_busy", 32'(load_ready), 32'd0);
            checkOutput("held_during_load", 32'(bcd_out), 32'(held));
            applyStimulus(0, keep_en, 1, 0, 0, 0, value);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; step_idx = '0; sat_mode = 1'b0;
        load_valid = 1'b0; bin_in = '0;

        // Reset held for three cycles.
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        cmp_on = 1'b1;
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        checkOutput("reset_bcd", 32'(bcd_out), 32'h000);
        checkOutput("reset_ready", 32'(load_ready), 32'd1);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_wrap", 32'(wrap), 32'd0);
`ifdef BCD_COUNTER_BLANK_EN
        checkOutput("reset_blank", 32'(blank), 32'b110);
`endif

        // Wrap up past 999.
        doLoad(998, 0, 12'h000);
        checkOutput("load998_bcd", 32'(bcd_out), 32'h998);
        checkOutput("load998_done", 32'(done), 32'd1);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("wrapup1_bcd", 32'(bcd_out), 32'h999);
        checkOutput("wrapup1_wrap", 32'(wrap), 32'd0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("wrapup2_bcd", 32'(bcd_out), 32'h000);
        checkOutput("wrapup2_wrap", 32'(wrap), 32'd1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("wrapup_idle_wrap", 32'(wrap), 32'd0);

        // Saturating decrement by ten from 5.
        doLoad(5, 0, 12'h000);
        checkOutput("load5_bcd", 32'(bcd_out), 32'h005);
        applyStimulus(0, 1, 0, 1, 1, 0, 0);
        checkOutput("satdn1_bcd", 32'(bcd_out), 32'h000);
        checkOutput("satdn1_wrap", 32'(wrap), 32'd1);
        applyStimulus(0, 1, 0, 1, 1, 0, 0);
        checkOutput("satdn2_bcd", 32'(bcd_out), 32'h000);
        checkOutput("satdn2_wrap", 32'(wrap), 32'd1);
        applyStimulus(0, 1, 0, 3, 1, 0, 0);
        checkOutput("step3_bcd", 32'(bcd_out), 32'h000);
        checkOutput("step3_wrap", 32'(wrap), 32'd0);

        // Preload timing and out-of-range preload.
        doLoad(437, 0, 12'h000);
        checkOutput("load437_bcd", 32'(bcd_out), 32'h437);
        checkOutput("load437_done", 32'(done), 32'd1);
        checkOutput("load437_err", 32'(load_err), 32'd0);
        checkOutput("load437_ready", 32'(load_ready), 32'd1);
        doLoad(1010, 0, 12'h437);
        checkOutput("load1010_bcd", 32'(bcd_out), 32'h999);
        checkOutput("load1010_done", 32'(done), 32'd1);
        checkOutput("load1010_err", 32'(load_err), 32'd1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("after_err_done", 32'(done), 32'd0);
        checkOutput("after_err_err", 32'(load_err), 32'd0);

        // Counting suppressed while a preload is in flight.
        doLoad(200, 1, 12'h999);
        checkOutput("supp_commit_bcd", 32'(bcd_out), 32'h200);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("supp_next_bcd", 32'(bcd_out), 32'h201);

        // Reset in the middle of a conversion.
        applyStimulus(0, 0, 1, 0, 0, 1, 500);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        checkOutput("abort_bcd", 32'(bcd_out), 32'h000);
        checkOutput("abort_ready", 32'(load_ready), 32'd1);
        for (int k = 0; k < 15; k++) begin
            applyStimulus(0, 0, 1, 0, 0, 0, 0);
            checkOutput("abort_no_done", 32'(done), 32'd0);
        end

`ifdef BCD_COUNTER_BLANK_EN
        doLoad(7, 0, 12'h000);
        checkOutput("blank_007", 32'(blank), 32'b110);
        doLoad(40, 0, 12'h007);
        checkOutput("blank_040", 32'(blank), 32'b100);
`endif

        // Randomised traffic checked against the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 1) == 1,
                          int'($urandom_range(0, 3)),
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 7) == 0,
                          int'($urandom_range(0, 1023)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
